tanh_sched: RTL and testbench
=============================

Name: tanh_sched

Overview:
- Shares one pipelined tanh unit between NREQ LSTM-side requesters, e.g. the gate-candidate path and the cell-state output path.
- Arbitrates with round-robin and supports burst lock, so one requester can stream a whole hidden vector uninterrupted.
- Issues at most one operand per cycle and tags every operand with its requester ID.
- Routes each tanh result back with that ID after a fixed latency. Sits between the gate/cell controllers and the external tanh instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 16, operand/result width, signed Q8.8
- LAT, 3, tanh pipeline latency in cycles from tanh_en to tanh_y (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_last  in  NREQ  marks final beat of requester's burst
- req_data  in  NREQ*DWIDTH  packed operands, requester i at [i*DWIDTH +: DWIDTH]
- req_ready  out  NREQ  per-requester accept
- tanh_en  out  1  operand valid to shared tanh
- tanh_x  out  DWIDTH  operand to shared tanh
- tanh_y  in  DWIDTH  tanh result, valid LAT cycles after tanh_en
- res_valid  out  1  result valid
- res_id  out  $clog2(NREQ)  owner of result
- res_data  out  DWIDTH  result (tanh_y pass-through)
- busy  out  1  burst locked or any result in flight

Behaviour:
- Reset (async, any time):
  - state=IDLE, rr_ptr=0, locked owner=0, tag pipeline all invalid.
  - tanh_en=0, tanh_x=0, res_valid=0, res_id=0, busy=0, req_ready=0.
  - In-flight results are discarded: tanh_y garbage is never flagged.
- Accept occurs at a clock edge when req_valid[i] & req_ready[i]. At most one req_ready bit is high per cycle, so at most one accept per cycle.
- States:
  - IDLE: req_ready is combinational. It is one-hot on the round-robin winner, the first i with req_valid[i] set, searching from rr_ptr upward with wrap. All zero if no valid.
    - On accept with last=1: stay IDLE, rr_ptr=(i+1)%NREQ.
    - On accept with last=0: go to BURST, owner=i.
  - BURST: req_ready[owner]=1, all other bits 0. The owner may drop valid (bubble) without losing the grant.
    - On accept with last=1: go to IDLE, rr_ptr=(owner+1)%NREQ.
- Issue: on an accept at edge k, tanh_en=1 and tanh_x=operand during cycle k+1. Otherwise tanh_en=0 and tanh_x holds its last value.
- Tag pipeline: LAT+1 stages of {valid, id}, shifted every cycle with no stall. Stage 0 loads {accept, i}.
- Output: res_valid/res_id are the final tag stage, aligned with tanh_y. res_data=tanh_y combinationally.
  - Total latency: accept edge k -> res_valid during cycle k+1+LAT.
  - Throughput: 1 result/cycle.
- No result backpressure: requesters must accept res_valid in the cycle it appears.
- Requesters must hold req_data/req_last stable while valid & !ready.
- busy = (state==BURST) | OR of all tag valids.
- Edge cases:
  - NREQ=1: the arbiter degenerates; rr_ptr stays 0.
  - A requester whose req_valid rises in the same cycle the ptr moves is evaluated against the new ptr on the next cycle only.
  - A requester may issue back-to-back single beats, but rotation places it last.

Decomposition:
- Shared package lstm_pkg holds:
  - DWIDTH/LAT defaults and the fixed-point typedef fix_t (logic signed [DWIDTH-1:0]).
  - Typedef tag_t {valid, id}.
  - Enum sched_state_t {IDLE, BURST}.
- One sub-module: rr_arbiter (combinational, NREQ req + ptr -> one-hot grant + encoded index), reusable for the sigmoid unit.
- Tag pipeline and FSM stay in tanh_sched.

Test Plan:
- Single beat: req0 valid, data 0x0100, last=1 -> ready[0] same cycle; tanh_en/tanh_x=0x0100 next cycle; res_valid, res_id=0, res_data=0x00C3 four cycles after accept (LAT=3).
- Round-robin: all four requesters valid, each with last=1 and data 0x0000 -> grants in order 0,1,2,3,0 on consecutive cycles; res_id sequence 0,1,2,3 with results 0x0000.
- Burst lock: req1 sends 8 beats (last on beat 8) while req2 is valid throughout, with a 2-cycle bubble after beat 3 -> req2 is never ready until after beat 8; its next grant follows immediately; busy stays 1 across the bubble.
- Pointer wrap: after a grant to req3, req0 and req3 both valid -> req0 wins.
- Reset mid-operation: assert rst with 3 results in flight and mid-burst -> all outputs 0 immediately (async), no res_valid after release, first post-reset grant goes to the lowest valid index.
- Saturation: operands 0x7FFF and 0x8000 -> res_data 0x0100 and 0xFF00, IDs correct, no dropped or duplicated results over 1000 random accepts (scoreboard count matches).

Source files
------------

// File: rtl/lstm_pkg.sv
// lstm_pkg: shared LSTM datapath defaults, fixed-point type, result tag and scheduler states
package lstm_pkg;
  localparam int DWIDTH_DEF = 16;
  localparam int LAT_DEF = 3;
  localparam int IDW = 3;
  typedef logic signed [DWIDTH_DEF-1:0] fix_t;
  typedef struct packed {
    logic valid;
    logic [IDW-1:0] id;
  } tag_t;
  typedef enum logic {IDLE, BURST} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, searching from ptr upward with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt = N'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/tanh_sched.sv
// tanh_sched: round-robin/burst-lock scheduler sharing one pipelined tanh unit, results tagged with requester id
module tanh_sched
  import lstm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LAT = LAT_DEF,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input logic clk,
  input logic rst,
  input logic [NREQ-1:0] req_valid,
  input logic [NREQ-1:0] req_last,
  input logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0] req_ready,
  output logic tanh_en,
  output logic [DWIDTH-1:0] tanh_x,
  input logic [DWIDTH-1:0] tanh_y,
  output logic res_valid,
  output logic [IW-1:0] res_id,
  output logic [DWIDTH-1:0] res_data,
  output logic busy
);
  sched_state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n, owner, owner_n, gnt_idx, aid;
  logic [NREQ-1:0] gnt;
  logic accept, alast, inflight;
  logic [DWIDTH-1:0] adata;
  tag_t tags [LAT+1];

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  always_comb begin
    aid = state == BURST ? owner : gnt_idx;
    req_ready = rst ? '0 : state == BURST ? NREQ'(1) << owner : gnt;
    accept = |(req_valid & req_ready);
    alast = req_last[aid];
    adata = req_data[int'(aid)*DWIDTH +: DWIDTH];
    state_n = accept ? (alast ? IDLE : BURST) : state;
    owner_n = accept && !alast ? aid : owner;
    rr_ptr_n = accept && alast ? (int'(aid) == NREQ - 1 ? '0 : aid + IW'(1)) : rr_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      tanh_en <= 1'b0;
      tanh_x <= '0;
      for (int s = 0; s <= LAT; s++) tags[s] <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      owner <= owner_n;
      tanh_en <= accept;
      if (accept) tanh_x <= adata;
      tags[0] <= {accept, IDW'(aid)};
      for (int s = 1; s <= LAT; s++) tags[s] <= tags[s-1];
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int s = 0; s <= LAT; s++) inflight |= tags[s].valid;
  end

  assign busy = state == BURST || inflight;
  assign res_valid = tags[LAT].valid;
  assign res_id = IW'(tags[LAT].id);
  assign res_data = tanh_y;
endmodule

// File: tb/tb_tanh_sched.sv
// tb_tanh_sched: directed and scoreboarded checks of tanh_sched with a 3-cycle tanh stand-in
module tb_tanh_sched;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid, req_last, req_ready;
  logic [63:0] req_data;
  logic tanh_en, res_valid, busy;
  logic [15:0] tanh_x, tanh_y, res_data;
  logic [1:0] res_id;
  logic [15:0] m [3];
  int nvec = 0, nbad = 0, npush = 0, npop = 0, acc = 0, mptr, mown;
  int ids [6] = '{3, 0, 1, 2, 3, 0};
  int qi [$];
  logic [15:0] qd [$];
  logic [3:0] pv, pl, ex;
  logic [15:0] pd [4];
  bit mburst, bub;
  int b;

  tanh_sched #(.NREQ(4), .DWIDTH(16), .LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .tanh_en(tanh_en), .tanh_x(tanh_x), .tanh_y(tanh_y),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [15:0] x);
    case (x)
      16'h0000: return 16'h0000;
      16'h0100: return 16'h00C3;
      16'h7FFF: return 16'h0100;
      16'h8000: return 16'hFF00;
      default:  return x ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    m[0] <= tanh_en ? f(tanh_x) : 16'hDEAD;
    m[1] <= m[0];
    m[2] <= m[1];
  end
  assign tanh_y = m[2];

  function automatic logic [3:0] rr(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return 4'b1 << ((p + k) % 4);
    return 4'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nbad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (res_valid) begin
      if (qd.size() == 0) chk("res_extra", res_valid, 0);
      else begin
        chk("res_id", res_id, qi.pop_front());
        chk("res_data", res_data, qd.pop_front());
        npop++;
      end
    end
  endtask

  task automatic offer(input string tag, input logic [3:0] expv);
    #1;
    chk(tag, req_ready, expv);
    for (int i = 0; i < 4; i++)
      if (expv[i] && req_valid[i]) begin
        qi.push_back(i);
        qd.push_back(f(req_data[i*16 +: 16]));
        npush++;
      end
  endtask

  initial begin
    rst = 1'b1; req_valid = '1; req_last = '0; req_data = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_en", tanh_en, 0);
    chk("rst_x", tanh_x, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_rid", res_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    // single beat, LAT=3
    req_valid = 4'b0001; req_last = 4'b0001; req_data[15:0] = 16'h0100;
    offer("t1_ready", 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_en", tanh_en, 1);
    chk("t1_x", tanh_x, 16'h0100);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_en_off", tanh_en, 0);
    chk("t1_x_hold", tanh_x, 16'h0100);
    tick();
    chk("t1_rv_early", res_valid, 0);
    tick();
    chk("t1_rv", res_valid, 1);
    chk("t1_rid", res_id, 0);
    chk("t1_rd", res_data, 16'h00C3);
    tick();
    chk("t1_idle_busy", busy, 0);
    // pointer wrap then round robin 0,1,2,3,0
    req_last = '1; req_data = '0;
    for (int n = 0; n < 9; n++) begin
      if (n < 6) begin
        req_valid = n < 2 ? 4'b1001 : 4'b1111;
        offer("t2_ready", 4'b1 << ids[n]);
      end
      tick();
      if (n == 5) req_valid = '0;
      chk("t2_rv", res_valid, n >= 3);
      if (n >= 3) chk("t2_rid", res_id, ids[n-3]);
    end
    // burst lock on req1 with 2-cycle bubble, req2 waiting
    req_data[47:32] = 16'h0200;
    for (int s = 0; s < 10; s++) begin
      bub = s == 3 || s == 4;
      b = s < 3 ? s : s - 2;
      req_valid = bub ? 4'b0100 : 4'b0110;
      req_last = (!bub && b == 7) ? 4'b0110 : 4'b0100;
      req_data[31:16] = 16'(16'h0010 + b);
      offer("t3_ready", 4'b0010);
      tick();
      chk("t3_busy", busy, 1);
    end
    req_valid = 4'b0100;
    offer("t3_next", 4'b0100);
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("t3_drained", busy, 0);
    chk("t3_q", qd.size(), 0);
    // async reset mid-burst with results in flight
    req_valid = 4'b0001; req_last = '0; req_data[15:0] = 16'h0300;
    for (int s = 0; s < 3; s++) begin
      offer("t4_ready", 4'b0001);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t4_ready0", req_ready, 0);
    chk("t4_en0", tanh_en, 0);
    chk("t4_x0", tanh_x, 0);
    chk("t4_rv0", res_valid, 0);
    chk("t4_rid0", res_id, 0);
    chk("t4_busy0", busy, 0);
    qi.delete(); qd.delete();
    req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t4_no_rv", res_valid, 0);
    end
    req_valid = 4'b1010; req_last = 4'b1010;
    offer("t4_first", 4'b0010);
    tick();
    req_valid = '0;
    repeat (5) tick();
    // saturation
    req_valid = 4'b0001; req_last = 4'b0001; req_data[15:0] = 16'h7FFF;
    offer("t5_ready_a", 4'b0001);
    tick();
    req_data[15:0] = 16'h8000;
    offer("t5_ready_b", 4'b0001);
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("t5_q", qd.size(), 0);
    // random traffic against an arbiter model and the result scoreboard
    npush = 0; npop = 0; mptr = 1; mburst = 0; mown = 0; pv = '0; pl = '0;
    for (int i = 0; i < 4; i++) pd[i] = '0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1'b1;
          pl[i] = 1'($urandom_range(1, 0));
          b = $urandom_range(7, 0);
          pd[i] = b == 0 ? 16'h7FFF : b == 1 ? 16'h8000 : 16'($urandom);
        end
      req_valid = pv; req_last = pl; req_data = {pd[3], pd[2], pd[1], pd[0]};
      ex = mburst ? 4'b1 << mown : rr(pv, mptr);
      offer("rr_ready", ex);
      for (int i = 0; i < 4; i++)
        if (ex[i] && pv[i]) begin
          acc++;
          pv[i] = 1'b0;
          if (pl[i]) begin mburst = 0; mptr = (i + 1) % 4; end
          else begin mburst = 1; mown = i; end
        end
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
    chk("rr_accepts", acc, 1000);
    chk("rr_results", npop, npush);
    chk("rr_q", qd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
